instr_fetch_unit: RTL

Instruction-fetch stage sitting directly upstream of the instruction memory. It owns the program counter, drives the memory byte address, and captures the returned 32-bit instruction into a registered fetch/decode slot. Decode consumes the slot through a valid/ready handshake, and execute redirects the PC on taken branches and jumps. Halt and an optional address-bounds fault stop fetching.

---
 rtl/instr_fetch_unit_if.sv | 28 ++
 rtl/instr_fetch_unit.sv | 128 ++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: bus bundle between the fetch stage, instruction memory,
// decode (slot handshake) and execute (redirect / halt).
//   master : the fetch unit (drives imem_addr, slot outputs, status)
//   slave  : the environment (memory, decode, execute)
interface instr_fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        running;
  logic        fault;

  modport master (
    output imem_addr, out_valid, out_instr, out_pc, out_pc_plus4, running, fault,
    input  imem_instr, redirect_valid, redirect_pc, halt, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_instr, out_pc, out_pc_plus4, running, fault,
    output imem_instr, redirect_valid, redirect_pc, halt, out_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, addresses the instruction memory and captures
// the combinationally returned word into a registered fetch/decode slot.
// Decode drains the slot with out_valid/out_ready; execute redirects the PC;
// halt stops fetching until reset.
//
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous active-high reset
//   bus  - instr_fetch_unit_if.master (imem_addr/imem_instr, redirect_valid/
//          redirect_pc, halt, out_valid/out_ready/out_instr/out_pc/
//          out_pc_plus4, running, fault)
//
// Build option: define FETCH_BOUNDS_EN to fault (sticky, state FAULT) on any
// capture attempt with pc > MEM_BYTES-4. Without it the sequential increment
// wraps from MEM_BYTES-4 to 0 and fault is tied low.
module instr_fetch_unit #(
  parameter int unsigned RESET_PC  = 0,
  parameter int unsigned MEM_BYTES = 72
) (
  input logic               clk,
  input logic               rst,
  instr_fetch_unit_if.master bus
);

  localparam logic [31:0] RST_PC  = 32'(RESET_PC);
  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HALTED
`ifdef FETCH_BOUNDS_EN
    , S_FAULT
`endif
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        running;
  logic        fault;

  logic        slot_free;
  logic [31:0] pc_inc;

  // Slot can take a new word if empty or being drained this same edge.
  assign slot_free = !out_valid || bus.out_ready;

`ifdef FETCH_BOUNDS_EN
  assign pc_inc = pc + 32'd4;
`else
  assign pc_inc = (pc == LAST_PC) ? 32'd0 : pc + 32'd4;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      pc           <= RST_PC;
      out_valid    <= 1'b0;
      out_instr    <= '0;
      out_pc       <= '0;
      out_pc_plus4 <= 32'd4;
      running      <= 1'b0;
      fault        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state   <= S_FETCH;
          running <= 1'b1;
        end
        S_FETCH: begin
          if (bus.redirect_valid) begin
            // Flush: the target is fetched on the following edge.
            pc        <= {bus.redirect_pc[31:2], 2'b00};
            out_valid <= 1'b0;
          end else if (bus.halt) begin
            out_valid <= 1'b0;
            running   <= 1'b0;
            state     <= S_HALTED;
          end else if (slot_free) begin
`ifdef FETCH_BOUNDS_EN
            if (pc > LAST_PC) begin
              fault     <= 1'b1;
              out_valid <= 1'b0;
              running   <= 1'b0;
              state     <= S_FAULT;
            end else
`endif
            begin
              out_instr    <= bus.imem_instr;
              out_pc       <= pc;
              out_pc_plus4 <= pc + 32'd4;
              out_valid    <= 1'b1;
              pc           <= pc_inc;
            end
          end
        end
        S_HALTED: begin
          out_valid <= 1'b0;
          running   <= 1'b0;
        end
`ifdef FETCH_BOUNDS_EN
        S_FAULT: begin
          out_valid <= 1'b0;
          running   <= 1'b0;
        end
`endif
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          running   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_addr    = pc;
  assign bus.out_valid    = out_valid;
  assign bus.out_instr    = out_instr;
  assign bus.out_pc       = out_pc;
  assign bus.out_pc_plus4 = out_pc_plus4;
  assign bus.running      = running;
  assign bus.fault        = fault;

endmodule
